// File: rtl/ahb_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB-Lite slave backed by a word-organised internal memory.
//               Decodes its address window, runs the address/data-phase
//               pipeline, inserts WAIT_STATES wait cycles per OKAY transfer,
//               performs little-endian byte-lane writes and answers illegal
//               accesses with the two-cycle ERROR response.
// Ports       : clk        - bus clock, rising edge
//               reset      - synchronous, active-low reset
//               HSEL       - slave select
//               HADDR      - transfer byte address (32)
//               HWRITE     - 1 = write, 0 = read
//               HSIZE      - 0 byte, 1 halfword, 2 word (3)
//               HTRANS     - IDLE/BUSY/NONSEQ/SEQ (2)
//               HWDATA     - write data, valid in data phase (32)
//               HREADY     - bus-level ready
//               HREADYOUT  - slave ready
//               HRESP      - 0 OKAY, 1 ERROR
//               HRDATA     - read data (32)
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int          c_idx_w     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] c_mem_words = 32'(MEM_WORDS);
    localparam bit          c_has_wait  = (WAIT_STATES > 0);
    localparam logic [3:0]  c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_wait = 3'd1;
    localparam logic [2:0] c_st_data = 3'd2;
    localparam logic [2:0] c_st_err1 = 3'd3;
    localparam logic [2:0] c_st_err2 = 3'd4;

    logic [2:0]         r_state;
    logic [3:0]         r_wait_cnt;
    logic               r_hreadyout;
    logic               r_hresp;
    logic [c_idx_w-1:0] r_index;
    logic [1:0]         r_lane;
    logic [1:0]         r_size;
    logic               r_write;
    logic [31:0]        r_mem [MEM_WORDS];

    logic [31:0] w_off;
    logic        w_in_range;
    logic        w_aligned;
    logic        w_legal;
    logic        w_accept;
    logic [3:0]  w_be;
    logic        w_unused;

    // ------------------------------------------------------------------
    // Address-phase decode (evaluated on the live bus at the accept edge)
    // ------------------------------------------------------------------
    assign w_off      = HADDR - ADDR_BASE;
    // The subtraction wraps below the base, so the lower bound is checked
    // on the raw address.
    assign w_in_range = (HADDR >= ADDR_BASE) && ({2'b00, w_off[31:2]} < c_mem_words);
    assign w_accept   = HSEL & HREADY & HTRANS[1];

    always_comb begin
        w_aligned = 1'b1;
        case (HSIZE)
            3'd1:    w_aligned = ~HADDR[0];
            3'd2:    w_aligned = (HADDR[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_legal = w_in_range && (HSIZE <= 3'd2) && w_aligned;

    // SEQ/NONSEQ and BUSY/IDLE are treated alike; low offset bits come
    // straight from HADDR.
    assign w_unused = ^{HTRANS[0], w_off[1:0]};

    // ------------------------------------------------------------------
    // Transfer FSM with registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_st_idle;
            r_wait_cnt  <= 4'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_index     <= '0;
            r_lane      <= 2'b00;
            r_size      <= 2'b00;
            r_write     <= 1'b0;
        end else begin
            case (r_state)
                // States in which HREADYOUT is high can take a new address phase.
                c_st_idle, c_st_data, c_st_err2: begin
                    if (w_accept) begin
                        r_index <= w_off[c_idx_w+1:2];
                        r_lane  <= HADDR[1:0];
                        r_size  <= HSIZE[1:0];
                        r_write <= HWRITE;
                        if (!w_legal) begin
                            r_state     <= c_st_err1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= 1'b1;
                        end else if (c_has_wait) begin
                            r_state     <= c_st_wait;
                            r_wait_cnt  <= c_wait_load;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= 1'b0;
                        end else begin
                            r_state     <= c_st_data;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= 1'b0;
                        end
                    end else begin
                        r_state     <= c_st_idle;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
                c_st_wait: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state     <= c_st_data;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt - 4'd1;
                    end
                end
                c_st_err1: begin
                    r_state     <= c_st_err2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte-lane write enables for the latched transfer
    // ------------------------------------------------------------------
    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_lane;
            2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Memory is not reset; a reset during a transfer suppresses the write.
    always_ff @(posedge clk) begin
        if (reset && (r_state == c_st_data) && r_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_index][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Read path is asynchronous so a read pipelined directly behind a
    // write to the same word sees the freshly committed data.
    assign HRDATA    = (r_state == c_st_data) ? r_mem[r_index] : 32'd0;
    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;

endmodule
`default_nettype wire

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite slave placed directly downstream of the bus master. It decodes its address window, runs the address/data-phase pipeline and inserts a configurable number of wait states. It stores data in an internal word-organised memory with byte-lane writes. Illegal accesses receive the two-cycle ERROR response.

Parameters:
- ADDR_BASE, 32'h10000000, byte base address of the slave window.
- MEM_WORDS, 256, memory depth in 32-bit words; window = ADDR_BASE .. ADDR_BASE+4*MEM_WORDS-1.
- WAIT_STATES, 1, number of HREADYOUT-low cycles inserted per OKAY transfer (0..15).

Ports:
- clk, input, 1, bus clock; all logic on rising edge.
- reset, input, 1, synchronous, active-low reset.
- HSEL, input, 1, slave select from the address decoder.
- HADDR, input, 32, transfer byte address.
- HWRITE, input, 1, 1 = write, 0 = read.
- HSIZE, input, 3, 0 = byte, 1 = halfword, 2 = word; others illegal.
- HTRANS, input, 2, 0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- HWDATA, input, 32, write data, valid in data phase.
- HREADY, input, 1, bus-level ready (previous transfer complete).
- HREADYOUT, output, 1, slave ready.
- HRESP, output, 1, 0 = OKAY, 1 = ERROR.
- HRDATA, output, 32, read data.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = IDLE; HREADYOUT = 1; HRESP = 0; HRDATA = 0; wait counter = 0.
  - Latched address-phase registers are cleared.
  - Memory contents are not reset.
  - Reset asserted mid-transfer aborts it: no memory write occurs, and the outputs take their reset values on the next edge.
- Address phase accepted when HSEL & HREADY & HTRANS[1] at a rising edge. Latch HADDR, HWRITE and HSIZE.
  - IDLE/BUSY, or HSEL = 0: no transfer; the next data phase is zero-wait OKAY.
- Legality check on the latched address:
  - HADDR >= ADDR_BASE.
  - (HADDR - ADDR_BASE) >> 2 < MEM_WORDS.
  - HSIZE <= 2.
  - Aligned: halfword needs addr[0] = 0; word needs addr[1:0] = 0.
  - Any failure leads to the ERROR sequence.
- States:
  - IDLE: HREADYOUT = 1, HRESP = 0.
    - Legal accept with WAIT_STATES > 0 → WAIT (counter loaded with WAIT_STATES-1).
    - Legal accept with WAIT_STATES == 0 → DATA.
    - Illegal accept → ERR1.
  - WAIT: HREADYOUT = 0, HRESP = 0; counter decrements; at 0 → DATA.
  - DATA: HREADYOUT = 1, HRESP = 0; the transfer completes this cycle. A new address phase may be accepted in the same cycle (pipelined), with the same transitions as IDLE; otherwise → IDLE.
  - ERR1: HREADYOUT = 0, HRESP = 1 → ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1. A new address phase may be accepted, with the same transitions as IDLE; otherwise → IDLE.
- Writes: HWDATA is sampled at the DATA-cycle edge. Little-endian byte lanes:
  - Byte: lane addr[1:0] is written.
  - Halfword: lanes {addr[1],0} and {addr[1],1} are written.
  - Word: all 4 lanes are written.
  - Unselected lanes are unchanged.
- Reads: in DATA, HRDATA = mem[index] (full 32-bit word, all lanes). In every other state HRDATA = 0.
  - A read following a write to the same word (back-to-back pipelined) returns the newly written data.
- ERROR transfers never modify memory.
- Consecutive NONSEQ/SEQ each pay WAIT_STATES; no burst optimisation. HBURST and HPROT are not ports and are ignored.
- Latency per OKAY transfer: WAIT_STATES+1 data-phase cycles. ERROR: 2 cycles.

Test Plan:
1. Reset check: hold reset = 0 for 2 clocks, then release → HREADYOUT = 1, HRESP = 0, HRDATA = 0; no transfer activity.
2. Word access, WAIT_STATES = 1: write 32'hDEADBEEF to 32'h10000010 (NONSEQ, HSIZE = 2), then read 32'h10000010.
   - Each data phase shows HREADYOUT = 0 for 1 cycle, then 1.
   - The read returns 32'hDEADBEEF with HRESP = 0.
3. Byte/halfword lanes: word 32'h10000020 = 32'h11223344.
   - Byte write 32'hAA000000 at 32'h10000023, then halfword write 32'h0000BBCC at 32'h10000020.
   - Word read returns 32'hAA22BBCC.
4. Errors:
   - Read 32'h20000000 (outside window, MEM_WORDS = 256) → ERR1 (HREADYOUT = 0, HRESP = 1), then ERR2 (HREADYOUT = 1, HRESP = 1).
   - Word write to 32'h10000002 (misaligned) → same 2-cycle ERROR, and the memory word at 32'h10000000 is unchanged.
5. Pipelined, WAIT_STATES = 0: NONSEQ write 32'h1 @ 32'h10000004, then read @ 32'h10000004, then IDLE, on consecutive cycles.
   - HREADYOUT stays 1 throughout.
   - The read returns 32'h00000001.
6. Abort: assert reset = 0 during the WAIT cycle of a write of 32'h55 to 32'h10000008, after first writing 32'h0 there.
   - Outputs return to reset values.
   - A subsequent read of 32'h10000008 returns 32'h0.
